// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller (master) and its datapath (slave).
// The controller reads the IR word and the ALU Zero flag and drives every select and write enable.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        zero;
    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic [1:0]  NPCOp;
    logic [1:0]  EXTOp;
    logic [3:0]  ALUOp;
    logic [1:0]  RegA3Sel;
    logic [1:0]  RegDataSel;
    logic [1:0]  AluBSel;
    logic [2:0]  state;
    logic        instr_done;

    modport master (
        input  instr, zero,
        output PCWrite, IRWrite, RegWrite, MemWrite,
        output NPCOp, EXTOp, ALUOp, RegA3Sel, RegDataSel, AluBSel,
        output state, instr_done
    );

    modport slave (
        output instr, zero,
        input  PCWrite, IRWrite, RegWrite, MemWrite,
        input  NPCOp, EXTOp, ALUOp, RegA3Sel, RegDataSel, AluBSel,
        input  state, instr_done
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with per-state write enables.
// Selects follow the decoded IR word in every state; enables depend on the registered state.
module multicycle_ctrl #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_NOP, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI,
        I_LW, I_SW, I_BEQ, I_J, I_JAL, I_UNK
    } iclass_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    iclass_t     cls;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    logic        pc_write, ir_write, reg_write, mem_write;
    logic [1:0]  npc_op, ext_op, reg_a3_sel, reg_data_sel, alu_b_sel;
    logic [3:0]  alu_op;

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];

    // An R-type word with an unlisted funct is a nop (retires in DECODE); an unlisted
    // opcode is unknown and walks through EXEC before retiring with PC+4.
    always_comb begin
        cls = I_UNK;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h21:   cls = I_ADDU;
                    6'h23:   cls = I_SUBU;
                    6'h08:   cls = I_JR;
                    default: cls = I_NOP;
                endcase
            end
            6'h0d:   cls = I_ORI;
            6'h0f:   cls = I_LUI;
            6'h23:   cls = I_LW;
            6'h2b:   cls = I_SW;
            6'h04:   cls = I_BEQ;
            6'h02:   cls = I_J;
            6'h03:   cls = I_JAL;
            default: cls = I_UNK;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        cnt_d   = 4'd0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (cls inside {I_J, I_JAL, I_JR, I_NOP}) state_d = S_FETCH;
                else                                      state_d = S_EXEC;
            end
            S_EXEC: begin
                if (cls == I_LW)                                   state_d = S_MEM;
                else if (cls inside {I_ADDU, I_SUBU, I_ORI, I_LUI}) state_d = S_WB;
                else                                               state_d = S_FETCH;
            end
            S_MEM: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_MEM;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        npc_op       = 2'b00;
        ext_op       = 2'b00;
        alu_op       = 4'b0000;
        reg_a3_sel   = 2'b00;
        reg_data_sel = 2'b00;
        alu_b_sel    = 2'b00;
        case (cls)
            I_SUBU: alu_op = 4'b0001;
            I_ORI: begin
                alu_op     = 4'b0010;
                alu_b_sel  = 2'b01;
                reg_a3_sel = 2'b01;
            end
            I_LUI: begin
                ext_op       = 2'b10;
                reg_a3_sel   = 2'b01;
                reg_data_sel = 2'b10;
            end
            I_LW: begin
                ext_op       = 2'b01;
                alu_b_sel    = 2'b01;
                reg_a3_sel   = 2'b01;
                reg_data_sel = 2'b01;
            end
            I_SW: begin
                ext_op    = 2'b01;
                alu_b_sel = 2'b01;
            end
            I_BEQ: begin
                alu_op = 4'b0001;
                npc_op = 2'b01;
            end
            I_J:   npc_op = 2'b10;
            I_JAL: begin
                npc_op       = 2'b10;
                reg_a3_sel   = 2'b10;
                reg_data_sel = 2'b11;
            end
            I_JR:  npc_op = 2'b11;
            default: ;
        endcase
    end

    // PCWrite fires only in the retiring state, so it doubles as the completion pulse.
    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            S_FETCH:  ir_write = 1'b1;
            S_DECODE: begin
                if (cls inside {I_J, I_JAL, I_JR, I_NOP}) begin
                    pc_write  = 1'b1;
                    reg_write = (cls == I_JAL);
                end
            end
            S_EXEC: begin
                if (cls inside {I_BEQ, I_SW, I_UNK}) begin
                    pc_write  = 1'b1;
                    mem_write = (cls == I_SW);
                end
            end
            S_WB: begin
                pc_write  = 1'b1;
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PCWrite    = pc_write;
    assign bus.IRWrite    = ir_write;
    assign bus.RegWrite   = reg_write;
    assign bus.MemWrite   = mem_write;
    assign bus.NPCOp      = npc_op;
    assign bus.EXTOp      = ext_op;
    assign bus.ALUOp      = alu_op;
    assign bus.RegA3Sel   = reg_a3_sel;
    assign bus.RegDataSel = reg_data_sel;
    assign bus.AluBSel    = alu_b_sel;
    assign bus.state      = state_q;
    assign bus.instr_done = pc_write;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed cases plus random instruction streams, each cycle
// compared with a per-instruction expectation built from the instruction-class rules.
module tb_multicycle_ctrl;

    localparam int MW = 2;

    localparam int K_NOP  = 0;
    localparam int K_ADDU = 1;
    localparam int K_SUBU = 2;
    localparam int K_JR   = 3;
    localparam int K_ORI  = 4;
    localparam int K_LUI  = 5;
    localparam int K_LW   = 6;
    localparam int K_SW   = 7;
    localparam int K_BEQ  = 8;
    localparam int K_J    = 9;
    localparam int K_JAL  = 10;
    localparam int K_UNK  = 11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    // entry: {state[2:0], IRWrite, PCWrite, RegWrite, MemWrite, instr_done, selects[13:0]}
    logic [21:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int classify(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00) begin
            if (fn == 6'h21) return K_ADDU;
            if (fn == 6'h23) return K_SUBU;
            if (fn == 6'h08) return K_JR;
            return K_NOP;
        end
        case (op)
            6'h0d: return K_ORI;
            6'h0f: return K_LUI;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h04: return K_BEQ;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_UNK;
        endcase
    endfunction

    // {NPCOp, EXTOp, ALUOp, RegA3Sel, RegDataSel, AluBSel}
    function automatic logic [13:0] expected_sels(input int k);
        case (k)
            K_ADDU: return {2'b00, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00};
            K_SUBU: return {2'b00, 2'b00, 4'b0001, 2'b00, 2'b00, 2'b00};
            K_ORI:  return {2'b00, 2'b00, 4'b0010, 2'b01, 2'b00, 2'b01};
            K_LUI:  return {2'b00, 2'b10, 4'b0000, 2'b01, 2'b10, 2'b00};
            K_LW:   return {2'b00, 2'b01, 4'b0000, 2'b01, 2'b01, 2'b01};
            K_SW:   return {2'b00, 2'b01, 4'b0000, 2'b00, 2'b00, 2'b01};
            K_BEQ:  return {2'b01, 2'b00, 4'b0001, 2'b00, 2'b00, 2'b00};
            K_J:    return {2'b10, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00};
            K_JAL:  return {2'b10, 2'b00, 4'b0000, 2'b10, 2'b11, 2'b00};
            K_JR:   return {2'b11, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00};
            default: return 14'd0;
        endcase
    endfunction

    task automatic build_expect(input logic [31:0] ins);
        int k;
        int st[$];
        logic [13:0] sel;
        logic last, irw, pcw, rw, mw;
        k   = classify(ins);
        sel = expected_sels(k);
        st.push_back(0);
        st.push_back(1);
        if (!(k inside {K_J, K_JAL, K_JR, K_NOP})) st.push_back(2);
        if (k == K_LW) for (int i = 0; i <= MW; i++) st.push_back(3);
        if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW}) st.push_back(4);
        exp_q.delete();
        for (int i = 0; i < st.size(); i++) begin
            last = (i == st.size() - 1);
            irw  = (st[i] == 0);
            pcw  = last;
            rw   = last && (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_JAL});
            mw   = last && (k == K_SW);
            exp_q.push_back({3'(st[i]), irw, pcw, rw, mw, pcw, sel});
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a posedge with the DUT in FETCH; returns in the same position.
    // abort_at >= 0 pulses reset right after cycle abort_at has been checked.
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic z,
                             input int abort_at);
        logic [21:0] e;
        int i;
        bus.instr = ins;
        bus.zero  = z;
        build_expect(ins);
        i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_val($sformatf("%s.c%0d.state", tag, i), 32'(bus.state), 32'(e[21:19]));
            check_val($sformatf("%s.c%0d.en", tag, i),
                      32'({bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.instr_done}),
                      32'(e[18:14]));
            check_val($sformatf("%s.c%0d.sel", tag, i),
                      32'({bus.NPCOp, bus.EXTOp, bus.ALUOp, bus.RegA3Sel, bus.RegDataSel, bus.AluBSel}),
                      32'(e[13:0]));
            if (i == abort_at) begin
                reset = 1'b1;
                exp_q.delete();
            end
            @(posedge clk);
            #1;
            reset = 1'b0;
            i++;
        end
    endtask

    function automatic logic [31:0] make_instr(input int k);
        logic [31:0] r;
        logic [5:0]  op;
        logic [5:0]  fn;
        r = $urandom;
        case (k)
            K_ADDU: r = {6'h00, r[25:11], 5'h00, 6'h21};
            K_SUBU: r = {6'h00, r[25:11], 5'h00, 6'h23};
            K_JR:   r = {6'h00, r[25:21], 15'h0, 6'h08};
            K_ORI:  r[31:26] = 6'h0d;
            K_LUI:  r[31:26] = 6'h0f;
            K_LW:   r[31:26] = 6'h23;
            K_SW:   r[31:26] = 6'h2b;
            K_BEQ:  r[31:26] = 6'h04;
            K_J:    r[31:26] = 6'h02;
            K_JAL:  r[31:26] = 6'h03;
            K_NOP: begin
                fn = 6'($urandom_range(0, 63));
                while (fn inside {6'h21, 6'h23, 6'h08}) fn = 6'($urandom_range(0, 63));
                r = {6'h00, r[25:6], fn};
            end
            default: begin
                op = 6'($urandom_range(1, 63));
                while (op inside {6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03})
                    op = 6'($urandom_range(1, 63));
                r[31:26] = op;
            end
        endcase
        return r;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int abort_at;
        reset     = 1'b1;
        bus.instr = 32'h0085_1021;
        bus.zero  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst.state", 32'(bus.state), 32'd0);
        check_val("rst.irwrite", 32'(bus.IRWrite), 32'd1);
        check_val("rst.writes", 32'({bus.PCWrite, bus.RegWrite, bus.MemWrite}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr("addu",   32'h0085_1021, 1'b0, -1);
        run_instr("lw",     32'h8C82_0004, 1'b0, -1);
        run_instr("beq_z1", 32'h1085_0003, 1'b1, -1);
        run_instr("beq_z0", 32'h1085_0003, 1'b0, -1);
        run_instr("jal",    32'h0C00_0C00, 1'b0, -1);
        run_instr("j",      32'h0800_0010, 1'b0, -1);
        run_instr("jr",     32'h03E0_0008, 1'b0, -1);
        run_instr("subu",   32'h0085_1023, 1'b0, -1);
        run_instr("ori",    32'h3482_00FF, 1'b0, -1);
        run_instr("lui",    32'h3C02_1234, 1'b0, -1);
        run_instr("sw",     32'hAC82_0008, 1'b1, -1);
        run_instr("nop",    32'h0000_0000, 1'b0, -1);
        // reset in the second MEM cycle, while the wait counter is non-zero
        run_instr("lw_abort",     32'h8C82_0004, 1'b0, 4);
        run_instr("lw_after_rst", 32'h8C82_0004, 1'b0, -1);
        run_instr("unknown",      32'hFC00_0000, 1'b0, -1);

        for (int n = 0; n < 300; n++) begin
            abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_instr($sformatf("rnd%0d", n), make_instr(int'($urandom_range(0, 11))),
                      1'($urandom_range(0, 1)), abort_at);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
